// File: rtl/switch_scan_ctrl.sv
// Slide-switch scanner: 2-flop sync, tick debounce, edge capture, Avalon-MM regs.
// Define SWITCH_SCAN_ANYEDGE_EN to capture falling as well as rising edges.
module switch_scan_ctrl #(
  parameter int          WIDTH           = 18,
  parameter int          CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_CAP   = 2'd2;
  localparam logic [1:0] ADDR_PER   = 2'd3;

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, sync_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_d;

  logic             wr_en, wr_mask, wr_cap, wr_per;
  logic [CNT_W-1:0] per_eff;
  logic             tick;
  logic [WIDTH-1:0] stable, rise, edge_set, clr;
  logic             unused_wd;

  assign unused_wd = &{1'b0, writedata};

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en & (address == ADDR_MASK);
  assign wr_cap  = wr_en & (address == ADDR_CAP);
  assign wr_per  = wr_en & (address == ADDR_PER);

  // A zero period behaves as one so the scanner can never stall.
  assign per_eff = (per_q == '0) ? CNT_ONE : per_q;
  assign tick    = ~wr_per & (cnt_q >= (per_eff - CNT_ONE));
  assign cnt_d   = (wr_per | tick) ? '0 : cnt_q + CNT_ONE;

  assign stable = ~(sync_q ^ samp_q);
  assign samp_d = tick ? sync_q : samp_q;
  assign deb_d  = tick ? ((deb_q & ~stable) | (sync_q & stable)) : deb_q;
  assign rise   = deb_d & ~deb_q;

`ifdef SWITCH_SCAN_ANYEDGE_EN
  logic [WIDTH-1:0] fall;
  assign fall     = deb_q & ~deb_d;
  assign edge_set = rise | fall;
`else
  assign edge_set = rise;
`endif

  // New edges override a simultaneous clear so no event is lost.
  assign clr    = wr_cap ? writedata[WIDTH-1:0] : '0;
  assign cap_d  = (cap_q & ~clr) | edge_set;
  assign mask_d = wr_mask ? writedata[WIDTH-1:0] : mask_q;
  assign per_d  = wr_per ? writedata[CNT_W-1:0] : per_q;

  always_comb begin
    rd_d = '0;
    unique case (address)
      ADDR_STATE: rd_d[WIDTH-1:0] = deb_q;
      ADDR_MASK:  rd_d[WIDTH-1:0] = mask_q;
      ADDR_CAP:   rd_d[WIDTH-1:0] = cap_q;
      ADDR_PER:   rd_d[CNT_W-1:0] = per_q;
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      sync_q   <= '0;
      samp_q   <= '0;
      deb_q    <= '0;
      cap_q    <= '0;
      mask_q   <= '0;
      per_q    <= PER_RST;
      cnt_q    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      s1_q     <= in_port;
      sync_q   <= s1_q;
      samp_q   <= samp_d;
      deb_q    <= deb_d;
      cap_q    <= cap_d;
      mask_q   <= mask_d;
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      readdata <= rd_d;
      irq      <= |(cap_q & mask_q);
    end
  end

endmodule
